// File: rtl/hot_collector_pkg.sv
// hot_collector_pkg: shared widths, epoch FSM states and history entry type for the hot address collector
package hot_collector_pkg;
    localparam int DEF_ADDR_SIZE = 33;
    localparam int DEF_STAT_SIZE = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_REQ} state_t;
    typedef struct packed {
        logic                     valid;
        logic [DEF_ADDR_SIZE-1:0] addr;
    } hist_t;
endpackage

// File: rtl/hot_addr_collector_if.sv
// hot_addr_collector_if: tracker stream, epoch query and CSR signals of the hot address collector
interface hot_addr_collector_if import hot_collector_pkg::*; #(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int PTR_SIZE  = 6,
    parameter int STAT_SIZE = DEF_STAT_SIZE
);
    logic                 mig_addr_en;
    logic [ADDR_SIZE-1:0] mig_addr;
    logic                 mig_addr_ready;
    logic                 query_en;
    logic                 query_ready;
    logic                 csr_enable;
    logic [31:0]          csr_epoch_cycles;
    logic                 csr_clear;
    logic                 csr_pop;
    logic                 csr_rd_valid;
    logic [ADDR_SIZE-1:0] csr_rd_addr;
    logic [PTR_SIZE:0]    csr_count;
    logic [STAT_SIZE-1:0] csr_dup_cnt;
    logic [STAT_SIZE-1:0] csr_drop_cnt;
    modport master (
        output mig_addr_en, mig_addr, query_ready, csr_enable, csr_epoch_cycles, csr_clear, csr_pop,
        input  mig_addr_ready, query_en, csr_rd_valid, csr_rd_addr, csr_count, csr_dup_cnt, csr_drop_cnt
    );
    modport slave (
        input  mig_addr_en, mig_addr, query_ready, csr_enable, csr_epoch_cycles, csr_clear, csr_pop,
        output mig_addr_ready, query_en, csr_rd_valid, csr_rd_addr, csr_count, csr_dup_cnt, csr_drop_cnt
    );
endinterface

// File: rtl/hot_addr_ring.sv
// hot_addr_ring: ring buffer of hot addresses; a pop frees room for a same-cycle push when full
module hot_addr_ring import hot_collector_pkg::*; #(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int DEPTH     = 64,
    parameter int PTR_SIZE  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic                 i_clear,
    input  logic [ADDR_SIZE-1:0] i_din,
    output logic [ADDR_SIZE-1:0] o_dout,
    output logic [PTR_SIZE:0]    o_count,
    output logic                 o_full,
    output logic                 o_empty
);
    logic [ADDR_SIZE-1:0] r_mem [DEPTH];
    logic [PTR_SIZE-1:0]  r_wr_ptr, r_rd_ptr;
    logic [PTR_SIZE:0]    r_count;
    logic                 w_do_push, w_do_pop;

    assign o_count   = r_count;
    assign o_full    = r_count == (PTR_SIZE+1)'(DEPTH);
    assign o_empty   = r_count == '0;
    assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty & ~i_clear;
    assign w_do_push = i_push & ~i_clear & (~o_full | w_do_pop);

    // storage write; contents need no reset since reads are gated by occupancy
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    // pointers wrap naturally at DEPTH; clear beats any push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_SIZE'(w_do_push);
            r_rd_ptr <= r_rd_ptr + PTR_SIZE'(w_do_pop);
            r_count  <= r_count + (PTR_SIZE+1)'(w_do_push) - (PTR_SIZE+1)'(w_do_pop);
        end
    end
endmodule

// File: rtl/hot_addr_collector.sv
// hot_addr_collector: dedups tracker hot addresses per epoch, buffers them for CSR pops, paces epoch queries
module hot_addr_collector import hot_collector_pkg::*; #(
    parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
    parameter int DEPTH      = 64,
    parameter int PTR_SIZE   = 6,
    parameter int NUM_RECENT = 4,
    parameter int STAT_SIZE  = DEF_STAT_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    hot_addr_collector_if.slave  bus
);
    logic                 r_ready;
    state_t               r_state, w_state_nxt;
    logic [31:0]          r_timer, w_timer_nxt;
    hist_t                r_hist [NUM_RECENT];
    logic [STAT_SIZE-1:0] r_dup, r_drop;
    logic                 w_accept, w_match, w_push, w_pop, w_drop, w_full, w_empty, w_qhs;

    assign bus.mig_addr_ready = r_ready & ~bus.csr_clear;
    assign bus.query_en       = r_state == ST_REQ;
    assign bus.csr_rd_valid   = ~w_empty;
    assign bus.csr_dup_cnt    = r_dup;
    assign bus.csr_drop_cnt   = r_drop;
    assign w_accept           = bus.mig_addr_en & bus.mig_addr_ready;
    assign w_push             = w_accept & ~w_match;
    assign w_pop              = bus.csr_pop & ~w_empty;
    assign w_drop             = w_push & w_full & ~w_pop;
    assign w_qhs              = bus.query_en & bus.query_ready;

    hot_addr_ring #(.ADDR_SIZE(ADDR_SIZE), .DEPTH(DEPTH), .PTR_SIZE(PTR_SIZE)) u_ring (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (bus.csr_clear),
        .i_din   (bus.mig_addr),
        .o_dout  (bus.csr_rd_addr),
        .o_count (bus.csr_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ready comes up on the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ready <= 1'b0;
        else     r_ready <= 1'b1;
    end

    // an incoming address is a repeat if any live history entry holds it
    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < NUM_RECENT; i++)
            w_match = w_match | (r_hist[i].valid && r_hist[i].addr == bus.mig_addr);
    end

    // history: newest at index 0; dropped addresses still enter, epoch handshake forgets everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RECENT; i++) r_hist[i] <= '0;
        end else if (bus.csr_clear || w_qhs) begin
            for (int i = 0; i < NUM_RECENT; i++) r_hist[i].valid <= 1'b0;
        end else if (w_push) begin
            r_hist[0] <= '{valid: 1'b1, addr: bus.mig_addr};
            for (int i = 1; i < NUM_RECENT; i++) r_hist[i] <= r_hist[i-1];
        end
    end

    // saturating duplicate and overflow-drop counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.csr_clear) begin
            r_dup  <= '0;
            r_drop <= '0;
        end else begin
            if (w_accept && w_match && !(&r_dup)) r_dup <= r_dup + 1'b1;
            if (w_drop && !(&r_drop)) r_drop <= r_drop + 1'b1;
        end
    end

    // epoch state and timer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // epoch sequencing: count out the epoch, then hold the query until the tracker takes it
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = '0;
        unique case (r_state)
            ST_IDLE:  if (bus.csr_enable && bus.csr_epoch_cycles != 32'd0) w_state_nxt = ST_COUNT;
            ST_COUNT: if (!bus.csr_enable || bus.csr_epoch_cycles == 32'd0) w_state_nxt = ST_IDLE;
                      else if (r_timer >= bus.csr_epoch_cycles - 32'd1) w_state_nxt = ST_REQ;
                      else w_timer_nxt = r_timer + 32'd1;
            ST_REQ:   if (bus.query_ready) w_state_nxt = bus.csr_enable ? ST_COUNT : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: doc/hot_addr_collector.md
Name: hot_addr_collector

Overview:
- Sits directly downstream of the hot tracker top. It consumes the migration-address stream (mig_addr_en/mig_addr/mig_addr_ready) and drives that block's query_en on a programmable epoch timer.
- Filters repeat hot addresses within an epoch and buffers the unique ones in a ring buffer. Host software pops the buffer through CSR registers.
- Counts duplicates and overflow drops for software visibility.

Parameters:
- ADDR_SIZE, 33, width of migration address
- DEPTH, 64, ring buffer entries (power of 2)
- PTR_SIZE, 6, log2(DEPTH)
- NUM_RECENT, 4, recent-address dedup history entries
- STAT_SIZE, 32, width of statistic counters

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- mig_addr_en  in  1  valid of hot address from tracker
- mig_addr  in  ADDR_SIZE  hot address
- mig_addr_ready  out  1  ready to tracker
- query_en  out  1  epoch query request to tracker
- query_ready  in  1  tracker accepts query
- csr_enable  in  1  epoch timer enable
- csr_epoch_cycles  in  32  epoch length in clk cycles; 0 = timer disabled
- csr_clear  in  1  single-cycle flush pulse
- csr_pop  in  1  single-cycle pop pulse
- csr_rd_valid  out  1  buffer non-empty
- csr_rd_addr  out  ADDR_SIZE  head-of-buffer address
- csr_count  out  PTR_SIZE+1  occupancy
- csr_dup_cnt  out  STAT_SIZE  duplicates discarded (saturating)
- csr_drop_cnt  out  STAT_SIZE  addresses dropped due to full buffer (saturating)

Behaviour:
- Reset (async, rst=1): all outputs 0 except mig_addr_ready. Pointers, occupancy, timer, dedup history valids and stat counters are cleared. mig_addr_ready resets to 0 and goes 1 on the first clk edge after rst deasserts.
- mig_addr_ready: 1 whenever out of reset and csr_clear is low. Every handshake (en & ready) is consumed in that cycle; no back-pressure for a full buffer.
- Dedup on each accepted address:
  - Compare against NUM_RECENT history entries (valid & equal).
  - Match: discard and increment csr_dup_cnt. History is unchanged.
- Full buffer: a non-matching address with occupancy == DEPTH is dropped and csr_drop_cnt increments. The address is still shifted into history.
- Otherwise: write to mem[wr_ptr], advance wr_ptr (wrap mod DEPTH), shift address into history with the oldest entry evicted.
- Read side: csr_rd_addr = mem[rd_ptr], csr_rd_valid = (count != 0).
  - Latency: address written at edge N is visible on csr_rd_addr after edge N when the buffer was empty (1 cycle from handshake).
  - csr_pop with count == 0 is ignored. Otherwise rd_ptr advances (wrap).
- Simultaneous push and pop:
  - Count is unchanged.
  - When full, the pop frees space in the same cycle, so the push is accepted, not dropped.
- Epoch FSM states:
  - IDLE: timer = 0. If csr_enable and csr_epoch_cycles != 0, go to COUNT.
  - COUNT: timer increments each cycle. At timer == csr_epoch_cycles-1, go to REQ and set timer = 0. If csr_enable drops or epoch = 0, go to IDLE.
  - REQ: query_en = 1 (registered), held until query_ready is sampled 1. On handshake, all history valids are cleared so the new epoch can re-report addresses, then go to COUNT, or to IDLE if csr_enable is low. csr_enable falling while in REQ does not withdraw query_en.
- csr_clear (synchronous, highest priority):
  - Resets pointers, count, history and both stat counters.
  - A push or pop in the same cycle is ignored.
  - Does not affect the epoch FSM.
- Statistic counters saturate at all-ones; no wrap.
- rst asserted mid-epoch or mid-REQ: immediate return to IDLE, query_en = 0.

Decomposition:
- Package hot_collector_pkg holds:
  - state enum {ST_IDLE, ST_COUNT, ST_REQ}
  - default widths (ADDR_SIZE, STAT_SIZE)
  - typedef for a history entry {valid, addr}
- Sub-module hot_addr_ring: synchronous ring buffer.
  - Inputs: push, pop, clear, din.
  - Outputs: dout, count, full, empty.
  - Storage for DEPTH x ADDR_SIZE plus pointer/occupancy logic.
- The top level holds the dedup history, stat counters and the epoch FSM.

Test Plan:
- Epoch timing: csr_enable=1, csr_epoch_cycles=100, query_ready held 0 for 5 cycles then 1 -> query_en rises 100 cycles after enable, held 6 cycles, then falls; the next query follows 100 cycles later.
- Dedup: push 0x1000, 0x2000, 0x1000, 0x3000 -> csr_count=3, csr_dup_cnt=1, pops return 0x1000, 0x2000, 0x3000. After an epoch handshake, pushing 0x1000 again -> accepted, csr_count increments.
- Overflow: push 66 distinct addresses with no pops -> csr_count=64, csr_drop_cnt=2, mig_addr_ready stays 1. Pop one while pushing a new address in the same cycle when full -> csr_count=64, csr_drop_cnt unchanged.
- Wrap: 200 push/pop pairs of distinct addresses -> in-order data, count never exceeds 1, csr_rd_valid correct at every step.
- Clear and reset: csr_clear coinciding with push and pop -> count=0, stats=0, the push is lost. Async rst asserted during REQ -> query_en=0 immediately, all outputs at reset values.
